// File: rtl/milano_dmem_resp.sv
// milano_dmem_resp: single-port data memory with LSU handshake, configurable wait states and optional error checking (MILANO_DMEM_ERR_EN)
module milano_dmem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [3:0]  lsu_opt_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam logic [3:0] LW = 4'd0, LH = 4'd1, LB = 4'd2, LBU = 4'd3, LHU = 4'd4;
  localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] op_q, op_c;
  logic [31:0] addr_q, wdata_q, addr_c, wdata_c;
  logic [31:0] rdata_q, rdata_nxt, word, wmask, wval, ld;
  logic err_q, err_c, acc, we, is_load, is_store;
  logic [ADDR_W-1:0] idx;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [31:0] mem [2**ADDR_W];
  // next-state, grant and wait-counter control
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    gnt_o = 1'b0;
    case (state)
      IDLE: begin
        gnt_o = req_i && !rst_i;
        if (gnt_o) begin
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
          cnt_nxt = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
        end
      end
      WAIT: begin
        state_nxt = (cnt == 4'd0) ? RESP : WAIT;
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // access decode: with zero wait states the access happens on the grant edge, so use the live inputs
  always_comb begin
    op_c = (state == IDLE) ? lsu_opt_i : op_q;
    addr_c = (state == IDLE) ? addr_i : addr_q;
    wdata_c = (state == IDLE) ? wdata_i : wdata_q;
    acc = (state_nxt == RESP) && (state != RESP);
    idx = addr_c[ADDR_W+1:2];
    is_load = (op_c == LW) || (op_c == LH) || (op_c == LB) || (op_c == LBU) || (op_c == LHU);
    is_store = (op_c == SB) || (op_c == SH) || (op_c == SW);
  end
`ifdef MILANO_DMEM_ERR_EN
  // misalignment, out-of-range and invalid opcodes all raise an error
  always_comb begin
    err_c = (((op_c == LW) || (op_c == SW)) && (addr_c[1:0] != 2'b00))
         || (((op_c == LH) || (op_c == LHU) || (op_c == SH)) && addr_c[0])
         || (|(addr_c >> (ADDR_W + 2)))
         || !(is_load || is_store);
  end
`else
  logic unused_hi;
  // errors disabled: upper address bits wrap, low bits are aligned down by lane selection
  always_comb begin
    err_c = 1'b0;
    unused_hi = ^addr_c[31:ADDR_W+2];
  end
`endif
  // lane masks for stores and sign/zero extension for loads
  always_comb begin
    word = mem[idx];
    rb = word[{addr_c[1:0], 3'b000} +: 8];
    rh = word[{addr_c[1], 4'b0000} +: 16];
    wmask = (op_c == SW) ? 32'hFFFF_FFFF
          : (op_c == SH) ? (32'h0000_FFFF << {addr_c[1], 4'b0000})
          : (op_c == SB) ? (32'h0000_00FF << {addr_c[1:0], 3'b000}) : 32'h0;
    wval = (op_c == SW) ? wdata_c : (op_c == SH) ? {2{wdata_c[15:0]}} : {4{wdata_c[7:0]}};
    ld = (op_c == LW)  ? word
       : (op_c == LH)  ? {{16{rh[15]}}, rh}
       : (op_c == LHU) ? {16'h0, rh}
       : (op_c == LB)  ? {{24{rb[7]}}, rb}
       : (op_c == LBU) ? {24'h0, rb} : 32'h0;
    rdata_nxt = err_c ? 32'h0 : ld;
    we = acc && is_store && !err_c;
  end
  // FSM state, captured request and registered response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      op_q <= 4'd0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (gnt_o) begin
        op_q <= lsu_opt_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
      end
      if (acc) begin
        rdata_q <= rdata_nxt;
        err_q <= err_c;
      end
    end
  end
  // memory array: no reset, byte-lane merge on store
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= (mem[idx] & ~wmask) | (wval & wmask);
  end
  assign rvalid_o = (state == RESP);
  assign rdata_o = rvalid_o ? rdata_q : 32'h0;
  assign err_o = rvalid_o && err_q;
endmodule

// File: tb/tb_milano_dmem_resp.sv
// tb_milano_dmem_resp: directed table-driven bench running WAIT_CYCLES=1 and WAIT_CYCLES=0 instances side by side
module tb_milano_dmem_resp;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic gnt1, rv1, err1, gnt0, rv0, err0;
  logic [31:0] rd1, rd0;
  int checks = 0, failures = 0;
`ifdef MILANO_DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          err;
  } vec_t;
  vec_t tv[23];

  always #5 clk = ~clk;

  milano_dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lsu_opt_i(op), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1));
  milano_dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lsu_opt_i(op), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0), .err_o(err0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xact(input int id, input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                      input logic [31:0] e1, input logic [31:0] e0, input bit ee);
    int l1 = 0, l0 = 0;
    bit d1 = 0, d0 = 0, leak = 0, q1 = 0, q0 = 0;
    logic [31:0] r1 = 0, r0 = 0;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = w;
    #1;
    chk($sformatf("v%0d gnt", id), 32'({gnt1, gnt0}), 32'b11);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 20 && !(d1 && d0); k++) begin
      if (k > 1) @(negedge clk);
      if (!d1 && rv1) begin d1 = 1; l1 = k; r1 = rd1; q1 = err1; end
      else if (!rv1 && (rd1 != 0 || err1)) leak = 1;
      if (!d0 && rv0) begin d0 = 1; l0 = k; r0 = rd0; q0 = err0; end
      else if (!rv0 && (rd0 != 0 || err0)) leak = 1;
      if ((gnt1 && rv1) || (gnt0 && rv0)) leak = 1;
    end
    chk($sformatf("v%0d lat_w1", id), 32'(l1), 32'd2);
    chk($sformatf("v%0d lat_w0", id), 32'(l0), 32'd1);
    chk($sformatf("v%0d rdata_w1", id), r1, e1);
    chk($sformatf("v%0d rdata_w0", id), r0, e0);
    chk($sformatf("v%0d err_w1", id), 32'(q1), 32'(ee));
    chk($sformatf("v%0d err_w0", id), 32'(q0), 32'(ee));
    chk($sformatf("v%0d idle_quiet", id), 32'(leak), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    tv[0]  = '{4'd7, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tv[1]  = '{4'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{4'd5, 32'h13, 32'h80, 32'h0, 1'b0};
    tv[3]  = '{4'd2, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0};
    tv[4]  = '{4'd3, 32'h13, 32'h0, 32'h00000080, 1'b0};
    tv[5]  = '{4'd0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0};
    tv[6]  = '{4'd6, 32'h12, 32'h1234, 32'h0, 1'b0};
    tv[7]  = '{4'd1, 32'h12, 32'h0, 32'h00001234, 1'b0};
    tv[8]  = '{4'd0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0};
    tv[9]  = '{4'd1, 32'h11, 32'h0, ERR ? 32'h0 : 32'hFFFFBEEF, ERR};
    tv[10] = '{4'd0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0};
    tv[11] = '{4'd8, 32'h10, 32'h0, 32'h0, ERR};
    tv[12] = '{4'd12, 32'h10, 32'hFFFFFFFF, 32'h0, ERR};
    tv[13] = '{4'd7, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0};
    tv[14] = '{4'd0, 32'h1000, 32'h0, ERR ? 32'h0 : 32'hCAFEF00D, ERR};
    tv[15] = '{4'd7, 32'h14, 32'h80017FFE, 32'h0, 1'b0};
    tv[16] = '{4'd4, 32'h16, 32'h0, 32'h00008001, 1'b0};
    tv[17] = '{4'd1, 32'h16, 32'h0, 32'hFFFF8001, 1'b0};
    tv[18] = '{4'd2, 32'h14, 32'h0, 32'hFFFFFFFE, 1'b0};
    tv[19] = '{4'd3, 32'h15, 32'h0, 32'h0000007F, 1'b0};
    tv[20] = '{4'd6, 32'h15, 32'hABCD, 32'h0, ERR};
    tv[21] = '{4'd0, 32'h14, 32'h0, ERR ? 32'h80017FFE : 32'h8001ABCD, 1'b0};
    tv[22] = '{4'd7, 32'h20, 32'h11, 32'h0, 1'b0};
    req = 1'b1;
    op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset gnt", 32'({gnt1, gnt0}), 32'b00);
    chk("reset rvalid", 32'({rv1, rv0}), 32'b00);
    chk("reset rdata", rd1 | rd0, 32'h0);
    chk("reset err", 32'({err1, err0}), 32'b00);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    foreach (tv[i]) xact(i, tv[i].op, tv[i].addr, tv[i].wdata, tv[i].exp, tv[i].exp, tv[i].err);
    @(negedge clk);
    req = 1'b1; op = 4'd7; addr = 32'h20; wdata = 32'h55;
    #1;
    chk("rst_abort gnt", 32'(gnt1), 32'd1);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_abort rvalid_in_rst", 32'({rv1, rv0}), 32'b00);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rv1 || rv0) bad = 1;
    end
    chk("rst_abort no_rvalid", 32'(bad), 32'd0);
    xact(100, 4'd0, 32'h20, 32'h0, 32'h11, 32'h55, 1'b0);
    @(negedge clk);
    req = 1'b1; op = 4'd8; addr = 32'h0; wdata = 32'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("thru gnt c%0d", i), 32'(gnt0), 32'(i % 2 == 0));
      chk($sformatf("thru rvalid c%0d", i), 32'(rv0), 32'(i % 2 == 1));
      if ((gnt0 && rv0) || (gnt1 && rv1)) bad = 1;
    end
    chk("thru never_both", 32'(bad), 32'd0);
    req = 1'b0;
    repeat (4) @(negedge clk);
    xact(101, 4'd0, 32'h10, 32'h0, 32'h1234BEEF, 32'h1234BEEF, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/milano_dmem_resp.md
MILANO_DMEM_RESP -- requirements
Module: milano_dmem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait cycles between grant and response (0..15).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  1  LSU request; held with its payload stable until gnt_o.
REQ-006 lsu_opt_i  input  4  operation, lsu_opt_e encoding (LW=0, LH=1, LB=2, LBU=3, LHU=4, SB=5, SH=6, SW=7, NONE=8).
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  32  store data, LSB-aligned (SB uses [7:0], SH uses [15:0]).
REQ-009 gnt_o  output  1  request accepted this cycle.
REQ-010 rvalid_o  output  1  one-cycle response pulse.
REQ-011 rdata_o  output  32  load result; 0 for stores and errors.
REQ-012 err_o  output  1  access error, valid with rvalid_o.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-014 gnt_o SHALL be combinational: req_i AND state==IDLE; no grant in WAIT or RESP.
REQ-015 On grant, opcode, address and wdata are captured; next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-016 WAIT SHALL count WAIT_CYCLES cycles with a down-counter, then enter RESP.
REQ-017 RESP lasts exactly one cycle with rvalid_o=1 and always returns to IDLE.
REQ-018 Latency: a grant in cycle N produces rvalid_o in cycle N+1+WAIT_CYCLES.
REQ-019 Throughput: at most one request per 2+WAIT_CYCLES cycles.
REQ-020 Stores write the array on the edge entering RESP; SB writes byte lane addr[1:0], SH writes halfword lane addr[1], SW writes the full word.
REQ-021 Loads read on the edge entering RESP; LB/LH sign-extend, LBU/LHU zero-extend, LW returns the word.
REQ-022 A read and a store in consecutive requests to the same word: the read SHALL return the stored data.
REQ-023 The word index SHALL be addr[ADDR_W+1:2].
REQ-024 LSU_NONE or a reserved opcode (9..15) SHALL be granted and answered with rdata_o=0 and no array write.
REQ-025 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.

Reset
REQ-026 While rst_i=1: state=IDLE, counter=0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
REQ-027 Reset asserted in WAIT aborts the access: no response is issued and a pending store is not written.
REQ-028 Array contents are not reset and are undefined until written.

Configuration
REQ-029 Macro MILANO_DMEM_ERR_EN defined: err_o=1 in RESP for any of the following, with no array write and rdata_o=0 on an error:
- misaligned LW/SW (addr[1:0]!=0);
- misaligned LH/LHU/SH (addr[0]!=0);
- out-of-range access (addr[31:ADDR_W+2]!=0);
- LSU_NONE or a reserved opcode.
REQ-030 Macro MILANO_DMEM_ERR_EN undefined: err_o is tied to 0; misaligned addresses are aligned down (LW/SW ignore addr[1:0], halfword accesses ignore addr[0]); upper address bits are ignored, so accesses wrap modulo the array size.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, rvalid exactly 2 cycles after each grant (WAIT_CYCLES=1).
- SB 0x13 wdata=0x80 on the word above, then LB 0x13 -> 0xFFFFFF80 and LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH 0x12 wdata=0x1234, then LH 0x12 -> 0x00001234; with ERR_EN, LH 0x11 -> err_o=1, rdata 0, memory unchanged.
- req_i held high continuously with WAIT_CYCLES=0 -> gnt_o every second cycle, rvalid_o in each following cycle, never both high together.
- rst_i pulsed during WAIT of SW 0x20 wdata=0x55 -> no rvalid_o; a subsequent LW 0x20 returns the prior contents.
- With ERR_EN, LW 0x00001000 (ADDR_W=10) -> err_o=1; without ERR_EN, the same LW -> data of word 0, err_o=0.
